// File: rtl/dm_pkg.sv
// Shared types and constants for the DM copy/fill engine.
package dm_pkg;

  localparam int unsigned DM_ADDR_W = 16;
  localparam int unsigned DM_DATA_W = 16;
  localparam int unsigned DM_LEN_W  = 11;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dm_copy_state_t;

endpackage

// File: rtl/dm_copy_engine_if.sv
// Request/status and DM-port bundle for the copy engine.
interface dm_copy_engine_if
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = DM_ADDR_W,
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned LEN_W  = DM_LEN_W
);

  // Request side
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_data;
  logic              busy;
  logic              done;

  // DM port
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_re;
  logic              dm_we;
  logic [DATA_W-1:0] dm_wrt_data;
  logic [DATA_W-1:0] dm_rd_data;

  // Engine side: drives the DM port and reports status
  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_data, dm_rd_data,
    output busy, done, dm_addr, dm_re, dm_we, dm_wrt_data
  );

  // Environment side: requester plus the DM itself
  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_data, dm_rd_data,
    input  busy, done, dm_addr, dm_re, dm_we, dm_wrt_data
  );

endinterface

// File: rtl/dm_copy_engine.sv
// DM bus master that copies a block of words or fills a region with a constant.
module dm_copy_engine
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = DM_ADDR_W,
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned LEN_W  = DM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  dm_copy_engine_if.master  bus
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_READ  = 2'(READ);
  localparam logic [1:0] S_WRITE = 2'(WRITE);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  logic [1:0]        state_q,   state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  rem_q,     rem_d;
  logic [DATA_W-1:0] hold_q,    hold_d;
  logic [DATA_W-1:0] fill_q,    fill_d;
  logic              mode_q,    mode_d;

  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              re_q,      re_d;
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;

  // Next-state, datapath and registered-output decode (outputs follow the next state)
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    hold_d    = hold_q;
    fill_d    = fill_q;
    mode_d    = mode_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          src_ptr_d = bus.src_addr;
          dst_ptr_d = bus.dst_addr;
          rem_d     = bus.len;
          mode_d    = bus.mode;
          fill_d    = bus.fill_data;
          if (bus.len == '0) begin
            state_d = S_DONE;
          end else if (bus.mode == MODE_COPY) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_READ: begin
        // DM flopped rd_data at mid-cycle; take it at the end of the read cycle
        hold_d  = bus.dm_rd_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        src_ptr_d = src_ptr_q + ADDR_W'(1);
        dst_ptr_d = dst_ptr_q + ADDR_W'(1);
        rem_d     = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end else if (mode_q == MODE_FILL) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    re_d    = (state_d == S_READ);
    we_d    = (state_d == S_WRITE);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (re_d) begin
      addr_d = src_ptr_d;
    end
    if (we_d) begin
      addr_d  = dst_ptr_d;
      wdata_d = (mode_d == MODE_FILL) ? fill_d : hold_d;
    end
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      hold_q    <= '0;
      fill_q    <= '0;
      mode_q    <= MODE_COPY;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
      hold_q    <= hold_d;
      fill_q    <= fill_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      re_q      <= re_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.dm_re       = re_q;
  assign bus.dm_we       = we_q;
  assign bus.dm_addr     = addr_q;
  assign bus.dm_wrt_data = wdata_q;

endmodule

// File: tb/tb_dm_copy_engine.sv
// Self-checking bench for dm_copy_engine with a behavioural DM and reference memory.
module tb_dm_copy_engine;
  import dm_pkg::*;

  logic clk;
  logic rst_n;

  dm_copy_engine_if bus ();

  dm_copy_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  // DM model: acts on negedge, one access per cycle
  always @(negedge clk) begin
    if (bus.dm_we === 1'b1) mem[bus.dm_addr] <= bus.dm_wrt_data;
    if (bus.dm_re === 1'b1) bus.dm_rd_data <= mem[bus.dm_addr];
  end

  // Reference: ascending word-by-word transfer of the first nwords
  task automatic ref_apply(input logic m, input logic [15:0] s, input logic [15:0] d,
                           input int nwords, input logic [15:0] f);
    for (int i = 0; i < nwords; i++) begin
      if (m == MODE_FILL) ref_mem[16'(d + i)] = f;
      else                ref_mem[16'(d + i)] = ref_mem[16'(s + i)];
    end
  endtask

  function automatic int mem_diff(output int first);
    int cnt;
    cnt = 0;
    first = -1;
    for (int a = 0; a < 65536; a++) begin
      if (mem[a] !== ref_mem[a]) begin
        if (cnt == 0) first = a;
        cnt++;
      end
    end
    return cnt;
  endfunction

  // Start a transfer and watch it cycle by cycle; inject>0 pulses a second start mid-run
  task automatic run_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [10:0] n, input logic [15:0] f, input int inject,
                          output int cycles, output int perr, output int re_cnt, output int we_cnt);
    bit got_done;
    bit exp_re, exp_we;
    logic [15:0] exp_a;
    bus.mode = m; bus.src_addr = s; bus.dst_addr = d; bus.len = n; bus.fill_data = f;
    bus.start = 1'b1;
    @(posedge clk);
    cycles = 0; perr = 0; re_cnt = 0; we_cnt = 0; got_done = 0;
    while (!got_done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      bus.start = (cycles == inject);
      bus.src_addr = (cycles == inject) ? (s ^ 16'h0F0F) : s;
      bus.mode = (cycles == inject) ? ~m : m;
      exp_re = 0; exp_we = 0; exp_a = 16'h0;
      if (m == MODE_COPY) begin
        if (cycles <= 2 * int'(n)) begin
          exp_re = (cycles % 2) == 1;
          exp_we = !exp_re;
          exp_a  = exp_re ? 16'(s + (cycles - 1) / 2) : 16'(d + cycles / 2 - 1);
        end
      end else if (cycles <= int'(n)) begin
        exp_we = 1;
        exp_a  = 16'(d + cycles - 1);
      end
      if (bus.dm_re === 1'b1) re_cnt++;
      if (bus.dm_we === 1'b1) we_cnt++;
      if (bus.dm_re !== exp_re || bus.dm_we !== exp_we || bus.busy !== 1'b1) perr++;
      if ((exp_re || exp_we) && bus.dm_addr !== exp_a) perr++;
      if (exp_we && m == MODE_FILL && bus.dm_wrt_data !== f) perr++;
      if (bus.done === 1'b1) got_done = 1;
    end
    bus.start = 1'b0;
    bus.src_addr = s;
    bus.mode = m;
    @(negedge clk);
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dm_re !== 1'b0 || bus.dm_we !== 1'b0) perr++;
  endtask

  function automatic int exp_cycles(input logic m, input logic [10:0] n);
    if (n == 0) return 1;
    return (m == MODE_COPY) ? 2 * int'(n) + 1 : int'(n) + 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
    bus.len = '0; bus.fill_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++; if (bus.dm_re !== 1'b0) begin n_fail++; $display("FAIL reset_re got=%b exp=0", bus.dm_re); end
    n_checks++; if (bus.dm_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", bus.dm_we); end
    n_checks++; if (bus.dm_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0000", bus.dm_addr); end
    n_checks++; if (bus.dm_wrt_data !== 16'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0000", bus.dm_wrt_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_copy_basic();
    int cyc, perr, rc, wc, first, nd;
    for (int i = 0; i < 4; i++) begin
      mem[16'h010 + i] = 16'h00A0 + 16'(i);
      ref_mem[16'h010 + i] = 16'h00A0 + 16'(i);
    end
    run_xfer(MODE_COPY, 16'h0010, 16'h0200, 11'd4, 16'h0, 0, cyc, perr, rc, wc);
    ref_apply(MODE_COPY, 16'h0010, 16'h0200, 4, 16'h0);
    n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL copy_latency got=%0d exp=9", cyc); end
    n_checks++; if (perr !== 0 || rc !== 4 || wc !== 4) begin n_fail++; $display("FAIL copy_pattern errs=%0d re=%0d we=%0d exp 0/4/4", perr, rc, wc); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[16'h200 + i] !== 16'h00A0 + 16'(i)) begin
        n_fail++; $display("FAIL copy_word%0d got=%h exp=%h", i, mem[16'h200 + i], 16'h00A0 + 16'(i));
      end
    end
    nd = mem_diff(first);
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL copy_mem diffs=%0d first=%h exp 0", nd, first); end
  endtask

  task automatic test_fill_basic();
    int cyc, perr, rc, wc, first, nd;
    run_xfer(MODE_FILL, 16'h0, 16'h0300, 11'd3, 16'hBEEF, 0, cyc, perr, rc, wc);
    ref_apply(MODE_FILL, 16'h0, 16'h0300, 3, 16'hBEEF);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL fill_latency got=%0d exp=4", cyc); end
    n_checks++; if (perr !== 0 || rc !== 0 || wc !== 3) begin n_fail++; $display("FAIL fill_pattern errs=%0d re=%0d we=%0d exp 0/0/3", perr, rc, wc); end
    n_checks++; if (mem[16'h0302] !== 16'hBEEF) begin n_fail++; $display("FAIL fill_last got=%h exp=beef", mem[16'h0302]); end
    nd = mem_diff(first);
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL fill_mem diffs=%0d first=%h exp 0", nd, first); end
  endtask

  task automatic test_len_zero();
    int cyc, perr, rc, wc, first, nd;
    run_xfer(MODE_COPY, 16'h1234, 16'h4321, 11'd0, 16'h0, 0, cyc, perr, rc, wc);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL len0_latency got=%0d exp=1", cyc); end
    n_checks++; if (perr !== 0 || rc !== 0 || wc !== 0) begin n_fail++; $display("FAIL len0_pattern errs=%0d re=%0d we=%0d exp 0/0/0", perr, rc, wc); end
    nd = mem_diff(first);
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL len0_mem diffs=%0d first=%h exp 0", nd, first); end
  endtask

  task automatic test_overlap();
    int cyc, perr, rc, wc, first, nd;
    mem[16'h100] = 16'h1111; ref_mem[16'h100] = 16'h1111;
    run_xfer(MODE_COPY, 16'h0100, 16'h0101, 11'd3, 16'h0, 0, cyc, perr, rc, wc);
    ref_apply(MODE_COPY, 16'h0100, 16'h0101, 3, 16'h0);
    for (int i = 1; i <= 3; i++) begin
      n_checks++;
      if (mem[16'h100 + i] !== 16'h1111) begin
        n_fail++; $display("FAIL overlap_word%0d got=%h exp=1111", i, mem[16'h100 + i]);
      end
    end
    nd = mem_diff(first);
    n_checks++; if (nd !== 0 || perr !== 0) begin n_fail++; $display("FAIL overlap_mem diffs=%0d first=%h perr=%0d exp 0", nd, first, perr); end
  endtask

  task automatic test_start_while_busy();
    int cyc, perr, rc, wc, first, nd;
    run_xfer(MODE_COPY, 16'h0400, 16'h0800, 11'd6, 16'h0, 5, cyc, perr, rc, wc);
    ref_apply(MODE_COPY, 16'h0400, 16'h0800, 6, 16'h0);
    n_checks++; if (cyc !== 13 || perr !== 0) begin n_fail++; $display("FAIL busy_start cycles=%0d perr=%0d exp 13/0", cyc, perr); end
    nd = mem_diff(first);
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL busy_start_mem diffs=%0d first=%h exp 0", nd, first); end
  endtask

  task automatic test_wrap();
    int cyc, perr, rc, wc, first, nd;
    run_xfer(MODE_FILL, 16'h0, 16'hFFFE, 11'd4, 16'h5A5A, 0, cyc, perr, rc, wc);
    ref_apply(MODE_FILL, 16'h0, 16'hFFFE, 4, 16'h5A5A);
    n_checks++; if (mem[16'h0001] !== 16'h5A5A || perr !== 0) begin n_fail++; $display("FAIL wrap_fill got=%h perr=%0d exp 5a5a/0", mem[16'h0001], perr); end
    run_xfer(MODE_COPY, 16'hFFFF, 16'h0A00, 11'd3, 16'h0, 0, cyc, perr, rc, wc);
    ref_apply(MODE_COPY, 16'hFFFF, 16'h0A00, 3, 16'h0);
    nd = mem_diff(first);
    n_checks++; if (nd !== 0 || perr !== 0) begin n_fail++; $display("FAIL wrap_copy diffs=%0d first=%h perr=%0d exp 0", nd, first, perr); end
  endtask

  task automatic test_random();
    int cyc, perr, rc, wc, first, nd;
    logic m;
    logic [15:0] s, d, f;
    logic [10:0] n;
    for (int t = 0; t < 12; t++) begin
      m = 1'($urandom_range(1, 0));
      s = 16'($urandom);
      d = 16'($urandom);
      f = 16'($urandom);
      n = 11'($urandom_range(40, 0));
      run_xfer(m, s, d, n, f, 0, cyc, perr, rc, wc);
      ref_apply(m, s, d, int'(n), f);
      nd = mem_diff(first);
      n_checks++;
      if (cyc !== exp_cycles(m, n) || perr !== 0 || nd !== 0) begin
        n_fail++;
        $display("FAIL random%0d mode=%0d len=%0d cycles=%0d exp=%0d perr=%0d diffs=%0d first=%h", t, m, n, cyc, exp_cycles(m, n), perr, nd, first);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, perr, rc, wc, first, nd;
    bus.mode = MODE_COPY; bus.src_addr = 16'h0C00; bus.dst_addr = 16'h0D00;
    bus.len = 11'd8; bus.fill_data = 16'h0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.dm_re !== 1'b0 || bus.dm_we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs re=%b we=%b busy=%b done=%b exp 0000", bus.dm_re, bus.dm_we, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_nodone done=%b busy=%b exp 00", bus.done, bus.busy); end
    ref_apply(MODE_COPY, 16'h0C00, 16'h0D00, 2, 16'h0);
    nd = mem_diff(first);
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL rstmid_mem diffs=%0d first=%h exp 0", nd, first); end
    run_xfer(MODE_COPY, 16'h0C00, 16'h0D00, 11'd8, 16'h0, 0, cyc, perr, rc, wc);
    ref_apply(MODE_COPY, 16'h0C00, 16'h0D00, 8, 16'h0);
    nd = mem_diff(first);
    n_checks++; if (cyc !== 17 || perr !== 0 || nd !== 0) begin n_fail++; $display("FAIL rstmid_restart cycles=%0d perr=%0d diffs=%0d exp 17/0/0", cyc, perr, nd); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'($urandom);
      ref_mem[a] = mem[a];
    end
    bus.dm_rd_data = '0;
    test_reset();
    test_copy_basic();
    test_fill_basic();
    test_len_zero();
    test_overlap();
    test_start_while_busy();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_copy_engine.md
# dm_copy_engine

Initiator-side memory mover for the single-ported data memory (DM). On a start pulse it either copies a block of words from one DM region to another, or fills a region with a constant. It drives the DM's addr/re/we/wrt_data port and consumes rd_data. It sits beside the CPU as a DM bus master, and the DM-port arbiter (outside this block) grants it the port while busy is high.

## Interface
Parameters:
- ADDR_W, 16, DM address width
- DATA_W, 16, DM word width
- LEN_W, 11, transfer length width (max 1024 words)

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill; sampled with start
- src_addr  in  ADDR_W  copy source base
- dst_addr  in  ADDR_W  destination base
- len  in  LEN_W  word count
- fill_data  in  DATA_W  fill constant
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle pulse in DONE
- dm_addr  out  ADDR_W  to DM addr
- dm_re  out  1  to DM re
- dm_we  out  1  to DM we
- dm_wrt_data  out  DATA_W  to DM wrt_data
- dm_rd_data  in  DATA_W  from DM rd_data

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 latches src, dst, len, mode, and fill_data.
  - len==0 goes to DONE with no DM access.
  - Otherwise copy goes to READ, and fill goes to WRITE.
- READ (copy only):
  - dm_re=1, dm_we=0, dm_addr=src_ptr.
  - At the posedge that ends READ, capture dm_rd_data into hold_q and go to WRITE.
- WRITE:
  - dm_we=1, dm_re=0, dm_addr=dst_ptr.
  - dm_wrt_data is hold_q in copy mode and fill_data in fill mode.
  - On exit, increment both pointers and decrement remaining.
  - When remaining was 1, go to DONE.
  - Otherwise copy goes to READ and fill stays in WRITE.
- DONE: done=1 for one cycle, then IDLE.
- dm_re and dm_we are never both 1.
- Outside READ/WRITE, dm_re=dm_we=0, and dm_addr/dm_wrt_data hold their last value.
- Pointers are ADDR_W-bit modulo counters, so 0xFFFF wraps to 0x0000. Address decoding beyond DM depth is the DM's concern.
- Copy order is ascending with no overlap protection. If dst is in (src, src+len), the copy propagates as a forward smear, and this is the defined behaviour.
- start while busy is ignored. Inputs are not re-sampled mid-transfer.

## Timing
- All outputs are registered off posedge clk. The DM acts on negedge, so each DM access completes within the state's own cycle.
- Read latency: dm_re is asserted for the cycle. The DM flops rd_data at mid-cycle negedge. The engine captures it at the next posedge.
- Copy takes 2 cycles/word. Fill takes 1 cycle/word.
- Total cycles from start-accept posedge to done: copy 2·len+1, fill len+1, len==0 gives 1.
- busy goes high the cycle after start and low in the cycle after done.
- Reset values: busy=0, done=0, dm_re=0, dm_we=0, dm_addr=0, dm_wrt_data=0, state=IDLE, pointers/remaining/hold_q=0.
- Reset mid-transfer:
  - The next posedge forces IDLE with re/we=0.
  - Words already written stay written, and no done pulse is issued.
  - A write in the reset cycle itself still completes at that negedge.

## Structure
- Shared package dm_pkg holds:
  - the state enum dm_copy_state_t {IDLE, READ, WRITE, DONE}
  - DM_ADDR_W=16, DM_DATA_W=16, DM_LEN_W=11
  - mode constants MODE_COPY=1'b0, MODE_FILL=1'b1
- Single module with no sub-modules. The FSM, two pointer counters, a down-counter and the hold register are small enough to stay flat.

## Test plan
- Copy with mem[0x010..0x013]=0xA0..0xA3, src=0x010, dst=0x200, len=4:
  - mem[0x200..0x203]=0xA0..0xA3.
  - done occurs exactly 9 cycles after the start-accept.
  - re/we alternate and never overlap.
- Fill with dst=0x300, len=3, fill_data=0xBEEF:
  - mem[0x300..0x302]=0xBEEF.
  - Only we pulses, 3 consecutive cycles, and done on cycle 4.
- len=0:
  - done pulses 1 cycle after start.
  - dm_re/dm_we stay 0 throughout, and busy is high for one cycle.
- Overlap copy with mem[0x100]=0x1111, src=0x100, dst=0x101, len=3:
  - mem[0x101..0x103]=0x1111.
- Start while busy: a second start in mid-copy with different src is ignored, and the first transfer completes unchanged.
- Reset mid-copy: rst_n=0 after 2 words of an 8-word copy.
  - The next cycle has re=we=0, busy=0, and no done.
  - Only dst[0..1] (plus any word in the reset cycle) are modified.
  - A new start then runs correctly.
